ifu: RTL

Instruction fetch unit for the multi-cycle NPC core: the consumer end of the program-counter interface. It takes the current PC from `pcu`, fetches the instruction word from instruction memory over a valid/ready read channel (AR/R), and hands the instruction and its PC to decode with a valid/ready handshake. When decode accepts, it pulses the PC-advance enable back to `pcu`, so exactly one instruction is in flight at a time.

---
 rtl/ifu_pkg.sv | 21 ++
 rtl/ifu_stdreg.sv | 23 ++
 rtl/ifu.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// State encodings are fixed so they line up with the core's existing debug views.
package ifu_pkg;

  localparam int CPU_WIDTH = 32;

  localparam logic [CPU_WIDTH-1:0] NOP_INST  = 32'h0000_0013;
  localparam logic [1:0]           RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_AR   = 2'd1,
    IFU_R    = 2'd2,
    IFU_HOLD = 2'd3
  } ifu_state_e;

  function automatic logic pc_misaligned(input logic [CPU_WIDTH-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_stdreg.sv
// Generic load-enabled register with asynchronous active-low reset to RESET_VAL.
// Every piece of IFU state is held in one of these.
module ifu_stdreg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wen,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  // NOTE: non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dout <= RESET_VAL;
    end else if (i_wen) begin
      o_dout <= i_din;
    end
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: reads one instruction per PC over AR/R and hands it to
// decode; the PC-advance pulse keeps exactly one instruction in flight.
module ifu
  import ifu_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [CPU_WIDTH-1:0] i_pc,
  output logic                 o_pc_wen,
  output logic                 o_arvalid,
  input  logic                 i_arready,
  output logic [CPU_WIDTH-1:0] o_araddr,
  input  logic                 i_rvalid,
  output logic                 o_rready,
  input  logic [CPU_WIDTH-1:0] i_rdata,
  input  logic [1:0]           i_rresp,
  output logic                 o_inst_valid,
  input  logic                 i_inst_ready,
  output logic [CPU_WIDTH-1:0] o_inst,
  output logic [CPU_WIDTH-1:0] o_inst_pc,
  output logic                 o_fetch_err
);

  logic [1:0]           state_bits_q;
  ifu_state_e           state_q;
  ifu_state_e           state_d;
  logic                 inst_wen;
  logic [CPU_WIDTH-1:0] inst_d;
  logic                 inst_pc_wen;
  logic                 err_wen;
  logic                 err_d;

  assign state_q = ifu_state_e'(state_bits_q);

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    o_arvalid    = 1'b0;
    o_araddr     = '0;
    o_rready     = 1'b0;
    o_inst_valid = 1'b0;
    o_pc_wen     = 1'b0;
    inst_wen     = 1'b0;
    inst_d       = NOP_INST;
    inst_pc_wen  = 1'b0;
    err_wen      = 1'b0;
    err_d        = 1'b0;

    unique case (state_q)
      IFU_IDLE: state_d = IFU_AR;

      IFU_AR: begin
        if (pc_misaligned(i_pc)) begin
          // A misaligned PC never reaches the bus; decode sees a faulting NOP.
          inst_pc_wen = 1'b1;
          inst_wen    = 1'b1;
          err_wen     = 1'b1;
          err_d       = 1'b1;
          state_d     = IFU_HOLD;
        end else begin
          o_arvalid = 1'b1;
          o_araddr  = i_pc;
          if (i_arready) begin
            inst_pc_wen = 1'b1;
            state_d     = IFU_R;
          end
        end
      end

      IFU_R: begin
        o_rready = 1'b1;
        if (i_rvalid) begin
          inst_wen = 1'b1;
          err_wen  = 1'b1;
          err_d    = (i_rresp != RESP_OKAY);
          inst_d   = err_d ? NOP_INST : i_rdata;
          state_d  = IFU_HOLD;
        end
      end

      IFU_HOLD: begin
        o_inst_valid = 1'b1;
        if (i_inst_ready) begin
          o_pc_wen = 1'b1;
          state_d  = IFU_AR;
        end
      end

      default: state_d = IFU_IDLE;
    endcase
  end

  ifu_stdreg #(.WIDTH(2), .RESET_VAL(2'd0)) u_state_reg (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wen   (1'b1),
    .i_din   (state_d),
    .o_dout  (state_bits_q)
  );

  ifu_stdreg #(.WIDTH(CPU_WIDTH), .RESET_VAL('0)) u_inst_reg (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wen   (inst_wen),
    .i_din   (inst_d),
    .o_dout  (o_inst)
  );

  ifu_stdreg #(.WIDTH(CPU_WIDTH), .RESET_VAL('0)) u_inst_pc_reg (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wen   (inst_pc_wen),
    .i_din   (i_pc),
    .o_dout  (o_inst_pc)
  );

  ifu_stdreg #(.WIDTH(1), .RESET_VAL(1'b0)) u_err_reg (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wen   (err_wen),
    .i_din   (err_d),
    .o_dout  (o_fetch_err)
  );

endmodule
